seq_mult_param: RTL

//  Parametrised shift-add sequential multiplier with a start/done handshake.

---
 rtl/seq_mult_param.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_mult_param.sv
// ============================================================================
//  Module   : seq_mult_param
//  Purpose  : Shift-add sequential multiplier, WIDTH-generic, signed/unsigned
//             per operation, start rising-edge qualified, start/done handshake.
//  Option   : EARLY_TERM_EN - end the iteration phase once the multiplier is
//             exhausted (data-dependent latency, identical results).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult_param #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     A_in,
   input  logic [WIDTH-1:0]     B_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int         CW     = $clog2(WIDTH + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next;
   logic               r_start_q;
   logic               w_accept;
   logic               w_load;
   logic               w_last;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_result;
   logic [WIDTH-1:0]   r_mult;
   logic [CW-1:0]      r_count;
   logic               r_sign;
   logic               r_fin;

   assign w_accept = start & ~r_start_q;
   assign w_load   = w_accept & ((r_state == S_IDLE) | (r_state == S_DONE));

   // Magnitude of the most negative value still fits WIDTH bits unsigned
   assign w_a_mag = (signed_mode & A_in[WIDTH-1]) ? (-A_in) : A_in;
   assign w_b_mag = (signed_mode & B_in[WIDTH-1]) ? (-B_in) : B_in;

`ifdef EARLY_TERM_EN
   assign w_last = (r_count == CW'(WIDTH - 1)) || (r_mult[WIDTH-1:1] == '0);
`else
   assign w_last = (r_count == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_CALC;
         S_CALC:  if (r_fin)    w_next = S_DONE;
         S_DONE:  if (w_accept) w_next = S_CALC;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_CALC);
      done = (r_state == S_DONE);
   end

   // Datapath: r_fin marks that the final iteration has run, so the cycle
   // after it is spent applying the sign and publishing the product.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_q <= 1'b1;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_result  <= '0;
         r_mult    <= '0;
         r_count   <= '0;
         r_sign    <= 1'b0;
         r_fin     <= 1'b0;
      end else begin
         r_start_q <= start;
         if (w_load) begin
            r_mcand <= {{WIDTH{1'b0}}, w_a_mag};
            r_mult  <= w_b_mag;
            r_sign  <= signed_mode & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            r_acc   <= '0;
            r_count <= '0;
            r_fin   <= 1'b0;
         end else if (r_state == S_CALC) begin
            if (r_fin) begin
               r_result <= r_sign ? (-r_acc) : r_acc;
            end else begin
               if (r_mult[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand <= r_mcand << 1;
               r_mult  <= r_mult >> 1;
               r_count <= r_count + CW'(1);
               r_fin   <= w_last;
            end
         end
      end
   end

   assign result = r_result;

endmodule

`default_nettype wire
